// File: rtl/ab_cond_pkg.sv
// Shared types for the a/b input conditioner: debounce FSM states and synchroniser depth.
// Pure declarations; no logic, no latency, no flow control.
package ab_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_ch.sv
// One channel: two-flop synchroniser, debounce FSM/counter, registered level and rise pulse.
// Latency 2+DEBOUNCE_CYCLES edges from a stable raw change to the level; no backpressure.
module debounce_ch
  import ab_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   smp;
  deb_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   lvl_q;
  logic                   rise_q;

  assign smp  = sync_q[SYNC_STAGES-1];
  assign lvl  = lvl_q;
  assign rise = rise_q;

  // clr deliberately leaves the synchroniser alone so a held-high input re-qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (clr) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
      end else begin
        case (state_q)
          S_LOW: begin
            if (smp) begin
              state_q <= S_RISE;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          S_RISE: begin
            if (!smp) begin
              state_q <= S_LOW;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
              lvl_q   <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          S_HIGH: begin
            if (!smp) begin
              state_q <= S_FALL;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          S_FALL: begin
            if (smp) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= S_LOW;
              cnt_q   <= '0;
              lvl_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ab_input_conditioner.sv
// Conditions raw a/b inputs into clean levels and rise pulses for the next-state decoder.
// Latency 2+DEBOUNCE_CYCLES edges per channel; channels independent; no backpressure.
module ab_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .raw  (a_raw),
    .lvl  (a),
    .rise (a_rise)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .raw  (b_raw),
    .lvl  (b),
    .rise (b_rise)
  );

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Bench for ab_input_conditioner with DEBOUNCE_CYCLES=4: per-edge expected outputs queued, then popped and compared.
module tb_ab_input_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, a_rise, b_rise;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] v;
    int         edge_n;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  ab_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b),
    .a_rise(a_rise),
    .b_rise(b_rise)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic ea, input logic eb, input logic ear, input logic ebr,
                              input int e, input string tag);
    exp_t x;
    x.v      = {ea, eb, ear, ebr};
    x.edge_n = e;
    x.tag    = tag;
    return x;
  endfunction

  task automatic reinit();
    a_raw = 1'b0;
    b_raw = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t x;
    logic [3:0] got;
    a_raw = 1'b1;
    b_raw = 1'b1;
    rst_n = 1'b0;
    for (int e = 0; e < 3; e++) begin
      exp_q.push_back(mk(0, 0, 0, 0, e, "reset_hold"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      exp_q.push_back(mk(e >= 2 + D, e >= 2 + D, e == 2 + D, e == 2 + D, e, "reset_release"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t x;
    logic [3:0] got;
    reinit();
    // 3 edges high: rejected before the counter reaches D.
    for (int e = 0; e <= 10; e++) begin
      a_raw = (e < 3);
      exp_q.push_back(mk(0, 0, 0, 0, e, "glitch_short"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
    // D+1 edges high: accepted at edge 6, then falls at edge 11 after the drop at edge 5.
    for (int e = 0; e <= 13; e++) begin
      a_raw = (e < D + 1);
      exp_q.push_back(mk(e >= 6 && e < 11, 0, e == 6, 0, e, "glitch_min_pass"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
  endtask

  task automatic test_fall();
    exp_t x;
    logic [3:0] got;
    reinit();
    a_raw = 1'b1;
    for (int i = 0; i < 8; i++) step();
    a_raw = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      exp_q.push_back(mk(e < 2 + D, 0, 0, 0, e, "fall"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t x;
    logic [3:0] got;
    reinit();
    for (int e = 0; e <= 13; e++) begin
      a_raw = (e >= 4) ? 1'b1 : ((e % 2) == 0);
      exp_q.push_back(mk(e >= 10, 0, e == 10, 0, e, "bounce"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
  endtask

  task automatic test_clr();
    exp_t x;
    logic [3:0] got;
    reinit();
    // a high by edge 6, b in S_RISE with cnt=3 at edge 7, clr lands on edge 8.
    for (int e = 0; e <= 15; e++) begin
      a_raw = 1'b1;
      b_raw = (e >= 3);
      clr   = (e == 8);
      exp_q.push_back(mk((e >= 6 && e < 8) || e >= 13, e >= 13,
                         e == 6 || e == 13, e == 13, e, "clr"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t x;
    logic [3:0] got;
    reinit();
    for (int e = 0; e <= 8; e++) begin
      a_raw = 1'b1;
      b_raw = (e >= 4);
      exp_q.push_back(mk(e >= 6, 0, e == 6, 0, e, "rstmid_pre"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
    // b is in S_RISE with cnt=3 here; reset must clear a and b without waiting for a clock.
    rst_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, "rstmid_async"));
    #1;
    got = {a, b, a_rise, b_rise};
    x = exp_q.pop_front();
    checks++;
    if (got !== x.v) begin
      errors++;
      $display("FAIL %s got {a,b,ar,br}=%b exp %b", x.tag, got, x.v);
    end
    step();
    rst_n = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      exp_q.push_back(mk(e >= 2 + D, e >= 2 + D, e == 2 + D, e == 2 + D, e, "rstmid_post"));
      step();
      got = {a, b, a_rise, b_rise};
      x = exp_q.pop_front();
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s edge %0d got {a,b,ar,br}=%b exp %b", x.tag, x.edge_n, got, x.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_fall();
    test_bounce();
    test_clr();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
